// File: rtl/multi_blinker.sv
// Multi-channel LED blinker: one shared tick prescaler feeding NUM_CH independent
// off/on/blink/burst channel FSMs, configured through a valid/ready handshake.
module multi_blinker #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned TICK_FREQ = 1000,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned HALF_W    = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              cfg_err,
    output logic              tick,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam int unsigned DIV = CLK_FREQ / TICK_FREQ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DivLast = PW'(DIV - 1);

    typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModeBurst} mode_e;
    typedef enum logic [1:0] {StOff, StOn, StHi, StLo} state_e;

    logic [PW-1:0]     presc_q, presc_d;
    logic              ready_q;
    logic              err_q, err_d;
    logic              xfer;
    logic [HALF_W-1:0] half_eff;
    mode_e             mode;

    assign presc_d   = (presc_q == DivLast) ? '0 : presc_q + PW'(1);
    assign tick      = (presc_q == DivLast);
    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign xfer      = cfg_valid && ready_q;
    assign err_d     = xfer && (32'(cfg_ch) >= NUM_CH);
    // A zero half-period would never reach the reload point, so clamp it to one tick.
    assign half_eff  = (cfg_half == '0) ? HALF_W'(1) : cfg_half;
    assign mode      = mode_e'(cfg_mode);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e            state_q, state_d;
        logic [HALF_W-1:0] half_q, half_d, reload_q, reload_d;
        logic [CNT_W-1:0]  remain_q, remain_d;
        logic              burst_q, burst_d;
        logic              done_q, done_d;
        logic              led_q;
        logic              sel;

        assign sel = xfer && (cfg_ch == 3'(i));

        always_comb begin
            state_d  = state_q;
            half_d   = half_q;
            reload_d = reload_q;
            remain_d = remain_q;
            burst_d  = burst_q;
            done_d   = 1'b0;
            // A transfer overrides everything, including a coincident tick.
            if (sel) begin
                unique case (mode)
                    ModeOff: begin
                        state_d = StOff;
                        burst_d = 1'b0;
                    end
                    ModeOn: begin
                        state_d = StOn;
                        burst_d = 1'b0;
                    end
                    ModeBlink: begin
                        state_d  = StHi;
                        half_d   = half_eff;
                        reload_d = half_eff;
                        burst_d  = 1'b0;
                    end
                    ModeBurst: begin
                        if (cfg_count == '0) begin
                            state_d = StOff;
                            burst_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = StHi;
                            half_d   = half_eff;
                            reload_d = half_eff;
                            remain_d = cfg_count;
                            burst_d  = 1'b1;
                        end
                    end
                endcase
            end else if (tick && (state_q == StHi || state_q == StLo)) begin
                if (half_q == HALF_W'(1)) begin
                    half_d = reload_q;
                    if (state_q == StHi) begin
                        state_d = StLo;
                        if (burst_q && remain_q != '0) begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end else if (burst_q && remain_q == '0) begin
                        state_d = StOff;
                        burst_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StHi;
                    end
                end else begin
                    half_d = half_q - HALF_W'(1);
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= StOff;
                half_q   <= HALF_W'(1);
                reload_q <= HALF_W'(1);
                remain_q <= '0;
                burst_q  <= 1'b0;
                done_q   <= 1'b0;
                led_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                half_q   <= half_d;
                reload_q <= reload_d;
                remain_q <= remain_d;
                burst_q  <= burst_d;
                done_q   <= done_d;
                led_q    <= (state_d == StOn) || (state_d == StHi);
            end
        end

        assign led_out[i] = led_q;
        assign busy[i]    = (state_q == StHi) || (state_q == StLo);
        assign done[i]    = done_q;
    end

endmodule

// File: tb/tb_multi_blinker.sv
// Bench for multi_blinker (DIV=8, 3 channels): a per-cycle reference model feeds a
// scoreboard queue, and scenario tasks add timing checks derived from the LED behaviour.
module tb_multi_blinker;

    localparam int NCH = 3;
    localparam int DIV = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_half = '0;
    logic [7:0]  cfg_count = '0;
    logic        cfg_err;
    logic        tick;
    logic [2:0]  led_out;
    logic [2:0]  busy;
    logic [2:0]  done;

    int total = 0;
    int bad = 0;

    multi_blinker #(
        .CLK_FREQ (8),
        .TICK_FREQ(1),
        .NUM_CH   (3),
        .HALF_W   (16),
        .CNT_W    (8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .cfg_count(cfg_count),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .led_out  (led_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ready;
        logic       err;
        logic       tk;
        logic [2:0] led;
        logic [2:0] bsy;
        logic [2:0] dn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp, mon_got;

    // Reference model. Channel states: 0 off, 1 on, 2 high phase, 3 low phase.
    int m_cnt;
    int m_st[NCH];
    int m_left[NCH];
    int m_h[NCH];
    int m_rem[NCH];
    bit m_bm[NCH];
    bit [2:0] m_done;
    bit m_err;
    bit m_ready;

    task automatic model_reset();
        m_cnt = 0;
        m_done = '0;
        m_err = 0;
        m_ready = 0;
        for (int i = 0; i < NCH; i++) begin
            m_st[i] = 0; m_left[i] = 1; m_h[i] = 1; m_rem[i] = 0; m_bm[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit t;
        int hv;
        t = (m_cnt == DIV - 1);
        hv = (cfg_half == 0) ? 1 : int'(cfg_half);
        m_done = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_valid && m_ready && int'(cfg_ch) == i) begin
                m_bm[i] = 0;
                case (cfg_mode)
                    2'd0: m_st[i] = 0;
                    2'd1: m_st[i] = 1;
                    2'd2: begin m_st[i] = 2; m_h[i] = hv; m_left[i] = hv; end
                    default: begin
                        if (cfg_count == 0) begin
                            m_st[i] = 0; m_done[i] = 1;
                        end else begin
                            m_st[i] = 2; m_h[i] = hv; m_left[i] = hv;
                            m_rem[i] = int'(cfg_count); m_bm[i] = 1;
                        end
                    end
                endcase
            end else if (t && m_st[i] >= 2) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_left[i] = m_h[i];
                    if (m_st[i] == 2) begin
                        m_st[i] = 3;
                        if (m_bm[i]) m_rem[i]--;
                    end else if (m_bm[i] && m_rem[i] == 0) begin
                        m_st[i] = 0; m_bm[i] = 0; m_done[i] = 1;
                    end else begin
                        m_st[i] = 2;
                    end
                end
            end
        end
        m_err = cfg_valid && m_ready && int'(cfg_ch) >= NCH;
        m_cnt = (m_cnt + 1) % DIV;
        m_ready = 1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ready = m_ready;
        e.err = m_err;
        e.tk = (m_cnt == DIV - 1);
        e.dn = m_done;
        for (int i = 0; i < NCH; i++) begin
            e.led[i] = (m_st[i] == 1 || m_st[i] == 2);
            e.bsy[i] = (m_st[i] >= 2);
        end
        return e;
    endfunction

    // Scoreboard: expectation queued at the edge, compared against the DUT just after it.
    always @(posedge clock) begin
        if (reset_n) model_edge();
        else model_reset();
        sb.push_back(model_out());
        #1;
        mon_exp = sb.pop_front();
        mon_got = {cfg_ready, cfg_err, tick, led_out, busy, done};
        total++;
        if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL scoreboard t=%0t rdy/err/tick/led/busy/done got=%b/%b/%b/%b/%b/%b exp=%b/%b/%b/%b/%b/%b",
                     $time, mon_got.ready, mon_got.err, mon_got.tk, mon_got.led, mon_got.bsy,
                     mon_got.dn, mon_exp.ready, mon_exp.err, mon_exp.tk, mon_exp.led,
                     mon_exp.bsy, mon_exp.dn);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input int ch, input int mode, input int half, input int count);
        cfg_valid = 1'b1;
        cfg_ch = 3'(ch);
        cfg_mode = 2'(mode);
        cfg_half = 16'(half);
        cfg_count = 8'(count);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (tick) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        int ticks;
        step(2);
        total++;
        if ({cfg_ready, cfg_err, tick, led_out, busy, done} !== 12'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {cfg_ready, cfg_err, tick, led_out, busy, done});
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1);
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_release got=%b exp=1", cfg_ready);
        end
        ticks = 0;
        for (int c = 2; c <= 40; c++) begin
            step(1);
            if (tick) begin
                ticks++;
                total++;
                if (c % DIV != 7) begin
                    bad++;
                    $display("FAIL tick_spacing cycle=%0d exp_cycle_mod8=7", c);
                end
            end
        end
        total++;
        if (ticks != 5) begin
            bad++;
            $display("FAIL tick_count got=%0d exp=5", ticks);
        end
        total++;
        if (led_out !== 3'b000 || done !== 3'b000 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs led=%b done=%b err=%b exp=0", led_out, done, cfg_err);
        end
    endtask

    task automatic test_blink();
        int last, n;
        logic prev;
        send(0, 2, 2, 0);
        total++;
        if (led_out[0] !== 1'b1 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL blink_start led0=%b busy0=%b exp=1/1", led_out[0], busy[0]);
        end
        last = 0; n = 0; prev = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step(1);
            if (led_out[0] !== prev) begin
                total++;
                if (n == 0 && (c < 9 || c > 16)) begin
                    bad++;
                    $display("FAIL blink_first_phase got=%0d exp=9..16", c);
                end else if (n > 0 && c - last != 16) begin
                    bad++;
                    $display("FAIL blink_period got=%0d exp=16", c - last);
                end
                last = c; n++; prev = led_out[0];
            end
        end
        total++;
        if (n < 3) begin
            bad++;
            $display("FAIL blink_toggles got=%0d exp>=3", n);
        end
    endtask

    task automatic test_burst();
        bit ok;
        int run, pulses, dcount, dcyc, bcyc;
        logic pl, pb;
        wait_tick(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL burst_wait_tick got=timeout exp=tick");
        end
        send(1, 3, 1, 3);
        total++;
        if (led_out[1] !== 1'b1) begin
            bad++;
            $display("FAIL burst_start got=%b exp=1", led_out[1]);
        end
        run = 1; pulses = 1; dcount = 0; dcyc = -1; bcyc = -1; pl = 1'b1; pb = 1'b1;
        for (int c = 1; c < 60; c++) begin
            step(1);
            if (led_out[1] && !pl) begin
                pulses++;
                run = 1;
            end else if (led_out[1]) begin
                run++;
            end else if (pl) begin
                total++;
                if (run != 8) begin
                    bad++;
                    $display("FAIL burst_pulse_width got=%0d exp=8", run);
                end
            end
            if (done[1]) begin
                dcount++;
                dcyc = c;
            end
            if (!busy[1] && pb) bcyc = c;
            pl = led_out[1];
            pb = busy[1];
        end
        total++;
        if (pulses != 3 || dcount != 1 || dcyc != 48 || bcyc != 48) begin
            bad++;
            $display("FAIL burst_summary pulses=%0d done=%0d done_at=%0d busy_fall=%0d exp=3/1/48/48",
                     pulses, dcount, dcyc, bcyc);
        end
    endtask

    task automatic test_burst_zero();
        send(2, 3, 4, 0);
        total++;
        if (done[2] !== 1'b1 || led_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL burst_zero_done done2=%b led2=%b exp=1/0", done[2], led_out[2]);
        end
        step(1);
        total++;
        if (done[2] !== 1'b0 || led_out[2] !== 1'b0) begin
            bad++;
            $display("FAIL burst_zero_after done2=%b led2=%b exp=0/0", done[2], led_out[2]);
        end
    endtask

    task automatic test_invalid_and_coincident();
        bit ok;
        int run;
        int bad_ch[3] = '{3, 5, 7};
        for (int k = 0; k < 3; k++) begin
            send(bad_ch[k], 1, 1, 1);
            total++;
            if (cfg_err !== 1'b1 || led_out[2:1] !== 2'b00 || busy !== 3'b001) begin
                bad++;
                $display("FAIL invalid_ch ch=%0d err=%b led=%b busy=%b exp=1/x00/001",
                         bad_ch[k], cfg_err, led_out, busy);
            end
            step(1);
            total++;
            if (cfg_err !== 1'b0) begin
                bad++;
                $display("FAIL invalid_err_width got=%b exp=0", cfg_err);
            end
        end
        wait_tick(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL coincident_wait_tick got=timeout exp=tick");
        end
        send(2, 2, 1, 0);
        run = 0;
        for (int c = 0; c < 20 && led_out[2]; c++) begin
            run++;
            step(1);
        end
        total++;
        if (run != 8) begin
            bad++;
            $display("FAIL coincident_phase got=%0d exp=8", run);
        end
        send(2, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int dcount;
        send(0, 1, 0, 0);
        send(1, 2, 0, 0);
        send(2, 3, 1, 2);
        dcount = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (done[2]) dcount++;
        end
        total++;
        if (dcount != 1 || led_out[0] !== 1'b1 || busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back done2=%0d led0=%b busy1=%b exp=1/1/1",
                     dcount, led_out[0], busy[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int dcount;
        send(1, 3, 2, 4);
        step(12);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (led_out !== 3'b000 || busy !== 3'b000 || done !== 3'b000 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset led=%b busy=%b done=%b rdy=%b exp=0",
                     led_out, busy, done, cfg_ready);
        end
        step(2);
        @(negedge clock);
        reset_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (done !== 3'b000) dcount++;
        end
        total++;
        if (dcount != 0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_no_done done_cycles=%0d rdy=%b exp=0/1", dcount, cfg_ready);
        end
    endtask

    task automatic test_blink_then_on();
        int wrong;
        send(0, 2, 3, 0);
        step(10);
        send(0, 1, 0, 0);
        wrong = 0;
        for (int c = 0; c < 30; c++) begin
            if (led_out[0] !== 1'b1 || busy[0] !== 1'b0) wrong++;
            step(1);
        end
        total++;
        if (wrong != 0) begin
            bad++;
            $display("FAIL blink_then_on bad_cycles=%0d exp=0", wrong);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_blink();
        test_burst();
        test_burst_zero();
        test_invalid_and_coincident();
        test_back_to_back();
        test_reset_mid_burst();
        test_blink_then_on();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t exp=finish_before_timeout", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
